// File: rtl/seq_pkg.sv
// Shared definitions for the serial front end of the sequence detector.
// Holds the serializer state encoding and the helper that sizes the
// bit counter from the word length, so every file agrees on both.
package seq_pkg;

   // Serializer FSM states; the encoding is fixed so waveforms read the same everywhere
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } serState_t;

   // Counter width for a word of the given length; clamps to at least one bit
   function automatic int cntWidth(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_bit_serializer_if.sv
// Handshake and serial-output bundle of the PISO bit serializer.
//   din        parallel word offered by the source
//   din_valid  source has a word on din
//   din_ready  serializer takes a word this cycle
//   x_out      serial bit towards the detector input x
//   x_valid    x_out carries a data bit
//   x_last     x_out is the final bit of its word
//   busy       a word is being shifted
// master: the word source / detector side; slave: the serializer.
interface piso_bit_serializer_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             x_out;
   logic             x_valid;
   logic             x_last;
   logic             busy;

   modport master (
      output din, din_valid,
      input  din_ready, x_out, x_valid, x_last, busy
   );

   modport slave (
      input  din, din_valid,
      output din_ready, x_out, x_valid, x_last, busy
   );

endinterface

// File: rtl/serial_bit_counter.sv
// Bit position counter for the serializer.
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, clears the count
//   clear_i  load 0 (new word or return to idle)
//   incr_i   advance one bit position
//   cnt_o    current bit position, 0..WIDTH-1
//   tc_o     terminal count, high when cnt_o == WIDTH-1
module serial_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             incr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt_q;

   // Clear wins over increment; the count holds at the terminal value rather
   // than wrapping, so a stray increment can never alias back to bit 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (incr_i && (cnt_q != LAST_CNT)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == LAST_CNT);

endmodule

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage feeding the sequence detector's serial input.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// x_out. A new word can be taken in the cycle the last bit of the previous
// word is on the line, so consecutive words form one unbroken bit stream.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; discards any partly sent word
//   bus   slave side of piso_bit_serializer_if (din/din_valid/din_ready,
//         x_out/x_valid/x_last/busy)
module piso_bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   piso_bit_serializer_if.slave   bus
);

   localparam int               CNT_W      = cntWidth(WIDTH);
   localparam logic [CNT_W-1:0] PENULT_CNT = CNT_W'(WIDTH - 2);

   serState_t        state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             xOut_q, xOut_d;
   logic             xValid_q, xValid_d;
   logic             xLast_q, xLast_d;
   logic             busy_q, busy_d;

   logic             cntClear;
   logic             cntIncr;
   logic [CNT_W-1:0] cnt;
   logic             cntTerminal;
   logic             dinReady;
   logic             transfer;

   serial_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) bitCounter (
      .clk     (clk),
      .rst     (rst),
      .clear_i (cntClear),
      .incr_i  (cntIncr),
      .cnt_o   (cnt),
      .tc_o    (cntTerminal)
   );

   // Ready depends only on registered state, never on din_valid, so the
   // source can build its valid from ready without a combinational loop
   assign dinReady = (state_q == IDLE) | ((state_q == SHIFT) & cntTerminal);
   assign transfer = bus.din_valid & dinReady;

   // Next-state logic. On a transfer the first bit goes straight into the
   // output register and the shift register keeps the remaining bits, already
   // shifted once, so the first bit is on x_out the cycle after the edge.
   // x_last is set one cycle early so it lines up with bit WIDTH-1.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      xOut_d   = xOut_q;
      xValid_d = xValid_q;
      xLast_d  = xLast_q;
      busy_d   = busy_q;
      cntClear = 1'b0;
      cntIncr  = 1'b0;

      if (transfer) begin
         state_d  = SHIFT;
         shift_d  = LSB_FIRST ? (bus.din >> 1) : (bus.din << 1);
         xOut_d   = LSB_FIRST ? bus.din[0] : bus.din[WIDTH-1];
         xValid_d = 1'b1;
         xLast_d  = 1'b0;
         busy_d   = 1'b1;
         cntClear = 1'b1;
      end else if ((state_q == SHIFT) && cntTerminal) begin
         state_d  = IDLE;
         shift_d  = '0;
         xOut_d   = IDLE_BIT;
         xValid_d = 1'b0;
         xLast_d  = 1'b0;
         busy_d   = 1'b0;
         cntClear = 1'b1;
      end else if (state_q == SHIFT) begin
         shift_d  = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
         xOut_d   = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
         xLast_d  = (cnt == PENULT_CNT);
         cntIncr  = 1'b1;
      end
   end

   // FSM, shift register and output registers share one reset domain so a
   // mid-word reset drops the line to idle in the same instant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         xOut_q   <= IDLE_BIT;
         xValid_q <= 1'b0;
         xLast_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         xOut_q   <= xOut_d;
         xValid_q <= xValid_d;
         xLast_q  <= xLast_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.din_ready = dinReady;
   assign bus.x_out     = xOut_q;
   assign bus.x_valid   = xValid_q;
   assign bus.x_last    = xLast_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench for piso_bit_serializer.
// Instance A: MSB first, idle level 0 (table-driven vectors).
// Instance B: LSB first, idle level 1 (hand-written sequence).
// Observed vector is {x_out, x_valid, x_last, din_ready, busy}.
module tb_piso_bit_serializer;

   localparam logic [4:0] IDL  = 5'b00010;
   localparam logic [4:0] IDLB = 5'b10010;
   localparam logic [4:0] M1   = 5'b11001;
   localparam logic [4:0] M0   = 5'b01001;
   localparam logic [4:0] L1   = 5'b11111;
   localparam logic [4:0] L0   = 5'b01111;

   typedef struct {
      int         testId;
      logic [7:0] din;
      logic       valid;
      logic [4:0] exp;
   } vecRow_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   vecRow_t rows[$];

   piso_bit_serializer_if #(.WIDTH(8)) busA ();
   piso_bit_serializer_if #(.WIDTH(8)) busB ();

   piso_bit_serializer #(
      .WIDTH     (8),
      .LSB_FIRST (1'b0),
      .IDLE_BIT  (1'b0)
   ) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA)
   );

   piso_bit_serializer #(
      .WIDTH     (8),
      .LSB_FIRST (1'b1),
      .IDLE_BIT  (1'b1)
   ) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [4:0] sampleA();
      return {busA.x_out, busA.x_valid, busA.x_last, busA.din_ready, busA.busy};
   endfunction

   function automatic logic [4:0] sampleB();
      return {busB.x_out, busB.x_valid, busB.x_last, busB.din_ready, busB.busy};
   endfunction

   function automatic void pushRow(input int t, input logic [7:0] d, input logic v, input logic [4:0] e);
      vecRow_t r;
      r.testId = t;
      r.din    = d;
      r.valid  = v;
      r.exp    = e;
      rows.push_back(r);
   endfunction

   // Drive both sources, then advance to just after the next rising edge
   task automatic applyStimulus(input logic [7:0] dA, input logic vA, input logic [7:0] dB, input logic vB);
      busA.din       = dA;
      busA.din_valid = vA;
      busB.din       = dB;
      busB.din_valid = vB;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [4:0] actual, input logic [4:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b (x,valid,last,ready,busy)", name, actual, expected);
      end
   endtask

   int bitsB[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1};

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      busA.din = '0;
      busA.din_valid = 1'b0;
      busB.din = '0;
      busB.din_valid = 1'b0;

      // Test 1: single word 8'hA5 -> 1,0,1,0,0,1,0,1
      pushRow(1, 8'hA5, 1'b1, IDL);
      pushRow(1, 8'h00, 1'b0, M1);
      pushRow(1, 8'h00, 1'b0, M0);
      pushRow(1, 8'h00, 1'b0, M1);
      pushRow(1, 8'h00, 1'b0, M0);
      pushRow(1, 8'h00, 1'b0, M0);
      pushRow(1, 8'h00, 1'b0, M1);
      pushRow(1, 8'h00, 1'b0, M0);
      pushRow(1, 8'h00, 1'b0, L1);
      pushRow(1, 8'h00, 1'b0, IDL);
      // Test 2: 8'hA5 then 8'h3C back to back with valid held
      pushRow(2, 8'hA5, 1'b1, IDL);
      pushRow(2, 8'h3C, 1'b1, M1);
      pushRow(2, 8'h3C, 1'b1, M0);
      pushRow(2, 8'h3C, 1'b1, M1);
      pushRow(2, 8'h3C, 1'b1, M0);
      pushRow(2, 8'h3C, 1'b1, M0);
      pushRow(2, 8'h3C, 1'b1, M1);
      pushRow(2, 8'h3C, 1'b1, M0);
      pushRow(2, 8'h3C, 1'b1, L1);
      pushRow(2, 8'h00, 1'b0, M0);
      pushRow(2, 8'h00, 1'b0, M0);
      pushRow(2, 8'h00, 1'b0, M1);
      pushRow(2, 8'h00, 1'b0, M1);
      pushRow(2, 8'h00, 1'b0, M1);
      pushRow(2, 8'h00, 1'b0, M1);
      pushRow(2, 8'h00, 1'b0, M0);
      pushRow(2, 8'h00, 1'b0, L0);
      pushRow(2, 8'h00, 1'b0, IDL);
      // Test 5: 8'h96 (1,0,0,1,0,1,1,0) while din/valid churn during the word
      pushRow(5, 8'h96, 1'b1, IDL);
      pushRow(5, 8'hF0, 1'b1, M1);
      pushRow(5, 8'h0F, 1'b1, M0);
      pushRow(5, 8'hFF, 1'b1, M0);
      pushRow(5, 8'h00, 1'b1, M1);
      pushRow(5, 8'hAA, 1'b1, M0);
      pushRow(5, 8'h55, 1'b1, M1);
      pushRow(5, 8'hC3, 1'b1, M1);
      pushRow(5, 8'h00, 1'b0, L0);
      pushRow(5, 8'h00, 1'b0, IDL);
      // Test 6: detector words 8'b01010010 then 8'b11010000, contiguous stream
      pushRow(6, 8'h52, 1'b1, IDL);
      pushRow(6, 8'hD0, 1'b1, M0);
      pushRow(6, 8'hD0, 1'b1, M1);
      pushRow(6, 8'hD0, 1'b1, M0);
      pushRow(6, 8'hD0, 1'b1, M1);
      pushRow(6, 8'hD0, 1'b1, M0);
      pushRow(6, 8'hD0, 1'b1, M0);
      pushRow(6, 8'hD0, 1'b1, M1);
      pushRow(6, 8'hD0, 1'b1, L0);
      pushRow(6, 8'h00, 1'b0, M1);
      pushRow(6, 8'h00, 1'b0, M1);
      pushRow(6, 8'h00, 1'b0, M0);
      pushRow(6, 8'h00, 1'b0, M1);
      pushRow(6, 8'h00, 1'b0, M0);
      pushRow(6, 8'h00, 1'b0, M0);
      pushRow(6, 8'h00, 1'b0, M0);
      pushRow(6, 8'h00, 1'b0, L0);
      pushRow(6, 8'h00, 1'b0, IDL);

      // Reset state of both instances
      #2 rst = 1'b1;
      #1;
      checkOutput("reset_A", sampleA(), IDL);
      checkOutput("reset_B", sampleB(), IDLB);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < rows.size(); i++) begin
         checkOutput($sformatf("t%0d_row%0d", rows[i].testId, i), sampleA(), rows[i].exp);
         applyStimulus(rows[i].din, rows[i].valid, 8'h00, 1'b0);
      end

      // Test 3: 8'hFF in flight, async reset after three bits
      checkOutput("t3_idle", sampleA(), IDL);
      applyStimulus(8'hFF, 1'b1, 8'h00, 1'b0);
      checkOutput("t3_bit0", sampleA(), M1);
      applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("t3_bit1", sampleA(), M1);
      applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
      checkOutput("t3_bit2", sampleA(), M1);
      rst = 1'b1;
      #1;
      checkOutput("t3_rst_async", sampleA(), IDL);
      #3 rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
         checkOutput($sformatf("t3_after_rst%0d", k), sampleA(), IDL);
      end

      // Test 4: LSB first, 8'h01 then 8'hB4 back to back, idle level 1
      checkOutput("t4_idle", sampleB(), IDLB);
      applyStimulus(8'h00, 1'b0, 8'h01, 1'b1);
      for (int i = 0; i < 16; i++) begin
         logic lastBit;
         lastBit = ((i % 8) == 7);
         checkOutput($sformatf("t4_bit%0d", i), sampleB(),
                     {bitsB[i] != 0, 1'b1, lastBit, lastBit, 1'b1});
         applyStimulus(8'h00, 1'b0, 8'hB4, (i == 7));
      end
      checkOutput("t4_idle_end", sampleB(), IDLB);
      checkOutput("t4_A_quiet", sampleA(), IDL);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
